// File: rtl/packet_display_ctrl.sv
// Round-robins two 12-bit port fields onto six 7-seg chars; PKT_DISP_IDLE_EN adds revert-to-dash after idle frames.
// Latency: 3 decode cycles after acceptance, then commit on the first frame tick; hex updates the cycle after that tick.
// Backpressure: p*_ready is combinational, low while an update is in flight or the port's hold window is running.
module packet_display_ctrl #(
    parameter int HOLD_FRAMES = 30,
    parameter int IDLE_FRAMES = 120,
    parameter int CNT_W       = 8
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        vga_vs,
    input  logic        p0_valid,
    input  logic [11:0] p0_data,
    output logic        p0_ready,
    input  logic        p1_valid,
    input  logic [11:0] p1_data,
    output logic        p1_ready,
    output logic [7:0]  hex1,
    output logic [7:0]  hex2,
    output logic [7:0]  hex3,
    output logic [7:0]  hex4,
    output logic [7:0]  hex5,
    output logic [7:0]  hex6
);
    typedef enum logic [2:0] {IDLE, DEC0, DEC1, DEC2, WAIT_FRAME} state_t;

    localparam logic [7:0]       DASH    = 8'h40;
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_FRAMES);
    localparam logic [7:0]       SEG [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    state_t           state;
    logic             vs_q, tick;
    logic             elig0, elig1, grant1, accept;
    logic             commit, commit0, commit1, revert0, revert1;
    logic             last_grant, cur_port;
    logic [11:0]      cur_data;
    logic [7:0]       shadow0, shadow1, shadow2;
    logic [CNT_W-1:0] hold0, hold1;

    assign tick     = vs_q & ~vga_vs;
    assign elig0    = (state == IDLE) && (hold0 == '0) && p0_valid;
    assign elig1    = (state == IDLE) && (hold1 == '0) && p1_valid;
    assign grant1   = elig1 && (!elig0 || !last_grant);
    // Readys are forced low during reset so nothing looks accepted while state is being cleared.
    assign p0_ready = elig0 && !grant1 && !reset;
    assign p1_ready = grant1 && !reset;
    assign accept   = p0_ready || p1_ready;
    assign commit   = (state == WAIT_FRAME) && tick;
    assign commit0  = commit && !cur_port;
    assign commit1  = commit && cur_port;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vs_q       <= 1'b1;
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            cur_data   <= '0;
            shadow0    <= DASH;
            shadow1    <= DASH;
            shadow2    <= DASH;
        end else begin
            vs_q <= vga_vs;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_port   <= grant1;
                        cur_data   <= grant1 ? p1_data : p0_data;
                        last_grant <= grant1;
                        state      <= DEC0;
                    end
                end
                DEC0: begin
                    shadow0 <= SEG[cur_data[11:8]];
                    state   <= DEC1;
                end
                DEC1: begin
                    shadow1 <= SEG[cur_data[7:4]];
                    state   <= DEC2;
                end
                DEC2: begin
                    shadow2 <= SEG[cur_data[3:0]];
                    state   <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (tick) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            if (commit0)                  hold0 <= HOLD_LD;
            else if (tick && hold0 != '0) hold0 <= hold0 - 1'b1;
            if (commit1)                  hold1 <= HOLD_LD;
            else if (tick && hold1 != '0) hold1 <= hold1 - 1'b1;
        end
    end

`ifdef PKT_DISP_IDLE_EN
    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_FRAMES);

    logic [CNT_W-1:0] idle0, idle1;

    // Revert fires only on the tick that brings the count up to the limit; saturation keeps it one-shot.
    assign revert0 = tick && (idle0 == IDLE_LD - 1'b1);
    assign revert1 = tick && (idle1 == IDLE_LD - 1'b1);

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            idle0 <= '0;
            idle1 <= '0;
        end else begin
            if (commit0)                      idle0 <= '0;
            else if (tick && idle0 != IDLE_LD) idle0 <= idle0 + 1'b1;
            if (commit1)                      idle1 <= '0;
            else if (tick && idle1 != IDLE_LD) idle1 <= idle1 + 1'b1;
        end
    end
`else
    assign revert0 = 1'b0;
    assign revert1 = 1'b0;
`endif

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            {hex1, hex2, hex3} <= {3{DASH}};
            {hex4, hex5, hex6} <= {3{DASH}};
        end else begin
            if (commit0)      {hex1, hex2, hex3} <= {shadow0, shadow1, shadow2};
            else if (revert0) {hex1, hex2, hex3} <= {3{DASH}};
            if (commit1)      {hex4, hex5, hex6} <= {shadow0, shadow1, shadow2};
            else if (revert1) {hex4, hex5, hex6} <= {3{DASH}};
        end
    end
endmodule

// File: tb/tb_packet_display_ctrl.sv
// Bench for packet_display_ctrl: table of port updates, hand-built timing corners, then random traffic against a reference model.
module tb_packet_display_ctrl;
    localparam int         HOLD = 2;
    localparam int         IDLE = 3;
    localparam logic [7:0] DASH = 8'h40;
    localparam logic [47:0] ALL_DASH = {6{8'h40}};

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        vga_vs = 1'b1;
    logic        p0_valid = 1'b0, p1_valid = 1'b0;
    logic [11:0] p0_data = '0, p1_data = '0;
    logic        p0_ready, p1_ready;
    logic [7:0]  hex1, hex2, hex3, hex4, hex5, hex6;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] seg_ref [16];

    typedef struct {
        bit          port;
        logic [11:0] data;
        logic [23:0] exp_triple;
    } vec_t;
    vec_t tbl [6];

    packet_display_ctrl #(.HOLD_FRAMES(HOLD), .IDLE_FRAMES(IDLE), .CNT_W(4)) dut (
        .clk50(clk50), .reset(reset), .vga_vs(vga_vs),
        .p0_valid(p0_valid), .p0_data(p0_data), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_data(p1_data), .p1_ready(p1_ready),
        .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5), .hex6(hex6)
    );

    always #10 clk50 = ~clk50;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    function automatic logic [47:0] hex_all();
        return {hex1, hex2, hex3, hex4, hex5, hex6};
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    task automatic frame_tick();
        vga_vs = 1'b0;
        step();
        vga_vs = 1'b1;
        step();
    endtask

    task automatic do_reset();
        vga_vs = 1'b1; p0_valid = 1'b0; p1_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic set_port(input bit port, input bit v, input logic [11:0] d);
        if (port) begin p1_valid = v; p1_data = d; end
        else      begin p0_valid = v; p0_data = d; end
    endtask

    // Leaves the caller at a negedge with ready high when ok is set.
    task automatic wait_ready(input bit port, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk50);
            if ((port ? p1_ready : p0_ready) === 1'b1) ok = 1'b1;
            else step();
        end
    endtask

    task automatic send(input bit port, input logic [11:0] data, input logic [47:0] exp_before);
        bit ok = 1'b0;
        set_port(port, 1'b1, data);
        for (int a = 0; a < 4 && !ok; a++) begin
            wait_ready(port, ok);
            if (!ok) begin
                set_port(port, 1'b0, data);
                frame_tick();
                set_port(port, 1'b1, data);
            end
        end
        chk("grant_timeout", 48'(ok), 48'd1);
        step();
        set_port(port, 1'b0, data);
        step(); step(); step();
        @(negedge clk50);
        chk("pre_commit_hex", hex_all(), exp_before);
        frame_tick();
    endtask

    // Reference model state
    bit          m_busy, m_port, m_last, m_vs_prev;
    logic [11:0] m_data;
    int          m_acc_edge, edge_n;
    int          m_hold [2];
    int          m_idle [2];
    logic [7:0]  m_hex [6];

    initial begin
        logic [47:0] exp;
        bit ok;
        int vs_timer, rate;
        bit e0, e1, g0, g1, tick, commit;

        seg_ref = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        tbl[0] = '{1'b0, 12'h1A5, 24'h06776D};
        tbl[1] = '{1'b1, 12'hF00, 24'h713F3F};
        tbl[2] = '{1'b0, 12'h234, 24'h5B4F66};
        tbl[3] = '{1'b1, 12'h789, 24'h077F6F};
        tbl[4] = '{1'b0, 12'hBCD, 24'h7C395E};
        tbl[5] = '{1'b1, 12'hE06, 24'h793F7D};

        // Reset state
        do_reset();
        @(negedge clk50);
        chk("reset_hex", hex_all(), ALL_DASH);
        chk("reset_ready", 48'({p0_ready, p1_ready}), 48'd0);
        step();

        // Single update: ready for exactly one cycle, commit only on the tick
        p0_valid = 1'b1; p0_data = 12'h1A5;
        @(negedge clk50);
        chk("single_ready", 48'(p0_ready), 48'd1);
        step();
        @(negedge clk50);
        chk("single_ready_once", 48'(p0_ready), 48'd0);
        step(); step();
        p0_valid = 1'b0;
        step();
        @(negedge clk50);
        chk("single_pre_tick", hex_all(), ALL_DASH);
        frame_tick();
        chk("single_hex", hex_all(), {24'h06776D, {3{DASH}}});

        // Hold window: p0 held valid, ready only after the second tick
        p0_valid = 1'b1; p0_data = 12'h123;
        @(negedge clk50);
        chk("hold_t0", 48'(p0_ready), 48'd0);
        vga_vs = 1'b0;
        step();
        @(negedge clk50);
        chk("hold_t1", 48'(p0_ready), 48'd0);
        vga_vs = 1'b1;
        step(); step();
        @(negedge clk50);
        chk("hold_gap", 48'(p0_ready), 48'd0);
        vga_vs = 1'b0;
        step();
        @(negedge clk50);
        chk("hold_t2", 48'(p0_ready), 48'd1);
        p0_valid = 1'b0;
        vga_vs = 1'b1;
        step();

        // Late tick in DEC1 is ignored; earliest commit four cycles after acceptance
        do_reset();
        p1_valid = 1'b1; p1_data = 12'h0C4;
        wait_ready(1'b1, ok);
        chk("late_grant", 48'(ok), 48'd1);
        step();
        p1_valid = 1'b0;
        step();
        vga_vs = 1'b0;
        step();
        vga_vs = 1'b1;
        @(negedge clk50);
        chk("late_no_commit", hex_all(), ALL_DASH);
        step();
        vga_vs = 1'b0;
        @(negedge clk50);
        chk("late_pre_commit", hex_all(), ALL_DASH);
        step();
        vga_vs = 1'b1;
        @(negedge clk50);
        chk("late_commit", hex_all(), {{3{DASH}}, 24'h3F3966});
        step();

        // Asynchronous reset with an update in flight
        do_reset();
        send(1'b0, 12'h5A3, ALL_DASH);
        chk("rst_pre_hex", hex_all(), {24'h6D774F, {3{DASH}}});
        p0_valid = 1'b1; p0_data = 12'h111;
        p1_valid = 1'b1; p1_data = 12'h0FF;
        wait_ready(1'b1, ok);
        chk("rst_grant", 48'(ok), 48'd1);
        step(); step();
        @(negedge clk50);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_hex", hex_all(), ALL_DASH);
        chk("rst_async_ready", 48'({p0_ready, p1_ready}), 48'd0);
        @(negedge clk50);
        chk("rst_hold_ready", 48'({p0_ready, p1_ready}), 48'd0);
        @(posedge clk50);
        #1;
        p0_valid = 1'b0; p1_valid = 1'b0;
        reset = 1'b0;
        step();
        frame_tick();
        step(); step();
        chk("rst_discard", hex_all(), ALL_DASH);
        p0_valid = 1'b1;
        @(negedge clk50);
        chk("rst_hold_cleared", 48'(p0_ready), 48'd1);
        p0_valid = 1'b0;
        step();

        // Contention after reset: p0 first, p1 once the FSM is idle again
        do_reset();
        p0_valid = 1'b1; p0_data = 12'h3C7;
        p1_valid = 1'b1; p1_data = 12'hF00;
        @(negedge clk50);
        chk("cont_first", 48'({p0_ready, p1_ready}), 48'b10);
        step();
        @(negedge clk50);
        chk("cont_busy", 48'({p0_ready, p1_ready}), 48'b00);
        step(); step(); step();
        vga_vs = 1'b0;
        step();
        @(negedge clk50);
        chk("cont_second", 48'({p0_ready, p1_ready}), 48'b01);
        vga_vs = 1'b1;
        step();
        p0_valid = 1'b0; p1_valid = 1'b0;
        step(); step(); step();
        frame_tick();
        chk("cont_hex", hex_all(), {24'h4F3907, 24'h713F3F});

        // Idle revert (or persistence when the feature is off)
`ifdef PKT_DISP_IDLE_EN
        frame_tick(); frame_tick();
        chk("idle_two_ticks", hex_all(), {{3{DASH}}, 24'h713F3F});
        frame_tick();
        chk("idle_three_ticks", hex_all(), ALL_DASH);
`else
        for (int i = 0; i < 10; i++) frame_tick();
        chk("idle_persist", hex_all(), {24'h4F3907, 24'h713F3F});
`endif

        // Table of alternating port updates
        do_reset();
        exp = ALL_DASH;
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].port, tbl[i].data, exp);
            if (tbl[i].port) exp[23:0] = tbl[i].exp_triple;
            else             exp[47:24] = tbl[i].exp_triple;
            chk("table_hex", hex_all(), exp);
        end

        // Random traffic against the reference model
        do_reset();
        m_busy = 1'b0; m_last = 1'b1; m_vs_prev = 1'b1; m_port = 1'b0; m_data = '0;
        m_acc_edge = 0; edge_n = 0;
        for (int p = 0; p < 2; p++) begin m_hold[p] = 0; m_idle[p] = 0; end
        for (int k = 0; k < 6; k++) m_hex[k] = DASH;
        vs_timer = 5; rate = 50;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (vs_timer == 0) begin
                vga_vs = !vga_vs;
                vs_timer = vga_vs ? $urandom_range(24, 6) : $urandom_range(3, 1);
            end else begin
                vs_timer--;
            end
            if (cyc % 250 == 0) rate = $urandom_range(3, 0) * 30;
            p0_valid = ($urandom_range(99, 0) < rate);
            p1_valid = ($urandom_range(99, 0) < rate);
            p0_data  = 12'($urandom);
            p1_data  = 12'($urandom);
            @(negedge clk50);

            e0 = !m_busy && m_hold[0] == 0 && p0_valid;
            e1 = !m_busy && m_hold[1] == 0 && p1_valid;
            g1 = e1 && (!e0 || !m_last);
            g0 = e0 && !g1;
            chk("rand_ready", 48'({p0_ready, p1_ready}), 48'({g0, g1}));
            chk("rand_hex", hex_all(), {m_hex[0], m_hex[1], m_hex[2], m_hex[3], m_hex[4], m_hex[5]});

            // Effect of the coming clock edge
            tick = m_vs_prev && !vga_vs;
            m_vs_prev = vga_vs;
            commit = m_busy && tick && (edge_n >= m_acc_edge + 4);
            for (int p = 0; p < 2; p++) begin
                if (commit && m_port == p) begin
                    m_hold[p] = HOLD;
                    m_idle[p] = 0;
                    for (int r = 0; r < 3; r++) m_hex[3*p + r] = seg_ref[m_data[11 - 4*r -: 4]];
                end else begin
                    if (tick && m_hold[p] > 0) m_hold[p]--;
`ifdef PKT_DISP_IDLE_EN
                    if (tick && m_idle[p] < IDLE) begin
                        m_idle[p]++;
                        if (m_idle[p] == IDLE)
                            for (int r = 0; r < 3; r++) m_hex[3*p + r] = DASH;
                    end
`endif
                end
            end
            if (commit) m_busy = 1'b0;
            if (g0 || g1) begin
                m_busy = 1'b1;
                m_port = g1;
                m_data = g1 ? p1_data : p0_data;
                m_acc_edge = edge_n;
                m_last = g1;
            end
            edge_n++;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
